// File: rtl/jump_pkg.sv
// Shared definitions for the jump-target arbiter: datapath width, FSM state
// encoding and requester indices.
package jump_pkg;

   localparam int unsigned WORD_SIZE = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic REQ_BRANCH = 1'b0;
   localparam logic REQ_JUMP   = 1'b1;

endpackage

// File: rtl/target_adder.sv
// Combinational jump-target adder: target = pc + offset, modulo 2^word_size.
module target_adder
   import jump_pkg::*;
#(
   parameter int unsigned word_size = WORD_SIZE
) (
   input  logic [word_size-1:0] pc,
   input  logic [word_size-1:0] offset,
   output logic [word_size-1:0] target
);

   // Carry out is deliberately discarded.
   assign target = pc + offset;

endmodule

// File: rtl/jump_target_arbiter.sv
// Round-robin arbiter sharing one jump-target adder between the branch and
// jump paths; IDLE -> CALC -> DONE sequence with a four-phase release.
module jump_target_arbiter
   import jump_pkg::*;
#(
   parameter int unsigned word_size = WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic [word_size-1:0] pc0,
   input  logic [word_size-1:0] offset0,
   input  logic                 req1,
   input  logic [word_size-1:0] pc1,
   input  logic [word_size-1:0] offset1,
   output logic                 grant0,
   output logic                 grant1,
   output logic                 done0,
   output logic                 done1,
   output logic [word_size-1:0] jump_target,
   output logic                 misaligned,
   output logic                 busy
);

   state_e               state_q, state_d;
   logic                 last_winner_q, last_winner_d;
   logic                 sel_q, sel_d;
   logic [word_size-1:0] op_pc_q, op_pc_d;
   logic [word_size-1:0] op_off_q, op_off_d;
   logic [word_size-1:0] target_q, target_d;
   logic                 misaligned_q, misaligned_d;
   logic                 grant0_q, grant0_d;
   logic                 grant1_q, grant1_d;
   logic                 done0_q, done0_d;
   logic                 done1_q, done1_d;
   logic                 busy_q, busy_d;

   logic [word_size-1:0] sum;
   logic                 winner;
   logic                 sel_req;

   target_adder #(.word_size(word_size)) u_adder (
      .pc     (op_pc_q),
      .offset (op_off_q),
      .target (sum)
   );

   // On a tie the requester that did not win last time is served.
   assign winner  = (req0 && req1) ? ~last_winner_q : req1;
   assign sel_req = (sel_q == REQ_JUMP) ? req1 : req0;

   always_comb begin
      state_d       = state_q;
      last_winner_d = last_winner_q;
      sel_d         = sel_q;
      op_pc_d       = op_pc_q;
      op_off_d      = op_off_q;
      target_d      = target_q;
      misaligned_d  = misaligned_q;
      grant0_d      = grant0_q;
      grant1_d      = grant1_q;
      done0_d       = done0_q;
      done1_d       = done1_q;
      busy_d        = busy_q;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               sel_d         = winner;
               last_winner_d = winner;
               op_pc_d       = (winner == REQ_JUMP) ? pc1 : pc0;
               op_off_d      = (winner == REQ_JUMP) ? offset1 : offset0;
               grant0_d      = (winner == REQ_BRANCH);
               grant1_d      = (winner == REQ_JUMP);
               busy_d        = 1'b1;
               state_d       = S_CALC;
            end
         end
         S_CALC: begin
            target_d     = sum;
            misaligned_d = |sum[1:0];
            done0_d      = (sel_q == REQ_BRANCH);
            done1_d      = (sel_q == REQ_JUMP);
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (!sel_req) begin
               grant0_d = 1'b0;
               grant1_d = 1'b0;
               done0_d  = 1'b0;
               done1_d  = 1'b0;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            done0_d  = 1'b0;
            done1_d  = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         last_winner_q <= REQ_JUMP;
         sel_q         <= REQ_BRANCH;
         op_pc_q       <= '0;
         op_off_q      <= '0;
         target_q      <= '0;
         misaligned_q  <= 1'b0;
         grant0_q      <= 1'b0;
         grant1_q      <= 1'b0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_winner_q <= last_winner_d;
         sel_q         <= sel_d;
         op_pc_q       <= op_pc_d;
         op_off_q      <= op_off_d;
         target_q      <= target_d;
         misaligned_q  <= misaligned_d;
         grant0_q      <= grant0_d;
         grant1_q      <= grant1_d;
         done0_q       <= done0_d;
         done1_q       <= done1_d;
         busy_q        <= busy_d;
      end
   end

   assign grant0      = grant0_q;
   assign grant1      = grant1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign jump_target = target_q;
   assign misaligned  = misaligned_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_jump_target_arbiter.sv
// Randomized self-checking bench for jump_target_arbiter against a
// transaction-level model of arbitration, latency and the release handshake.
module tb_jump_target_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [31:0] pc0, offset0, pc1, offset1;
   logic        grant0, grant1, done0, done1, misaligned, busy;
   logic [31:0] jump_target;

   int vectors     = 0;
   int miscompares = 0;
   bit last_win    = 1'b1;

   jump_target_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (req0),
      .pc0         (pc0),
      .offset0     (offset0),
      .req1        (req1),
      .pc1         (pc1),
      .offset1     (offset1),
      .grant0      (grant0),
      .grant1      (grant1),
      .done0       (done0),
      .done1       (done1),
      .jump_target (jump_target),
      .misaligned  (misaligned),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_grants"}, {30'd0, grant1, grant0}, 32'd0);
      check_val({tag, "_dones"}, {30'd0, done1, done0}, 32'd0);
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Serve every requester in mask; called at a negedge with operands set.
   task automatic serve(input bit [1:0] mask, input bit early, input int hold, input bit scramble);
      bit [1:0]    pend;
      bit          w;
      logic [31:0] exp_t;
      logic [31:0] exp_one;
      pend = mask;
      req0 = mask[0];
      req1 = mask[1];
      while (pend != 2'b00) begin
         w       = (pend == 2'b11) ? ~last_win : pend[1];
         exp_t   = w ? (pc1 + offset1) : (pc0 + offset0);
         exp_one = w ? 32'd2 : 32'd1;
         step;
         check_val("grant", {30'd0, grant1, grant0}, exp_one);
         check_val("busy_on", {31'd0, busy}, 32'd1);
         check_val("done_before_calc", {30'd0, done1, done0}, 32'd0);
         last_win = w;
         if (scramble) begin
            if (w) begin pc1 = $urandom; offset1 = $urandom; end
            else   begin pc0 = $urandom; offset0 = $urandom; end
         end
         if (early) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
         end
         step;
         check_val("done", {30'd0, done1, done0}, exp_one);
         check_val("grant_hold", {30'd0, grant1, grant0}, exp_one);
         check_val("target", jump_target, exp_t);
         check_val("misaligned", {31'd0, misaligned}, {31'd0, (exp_t % 4) != 0});
         if (!early) begin
            for (int i = 0; i < hold; i++) begin
               step;
               check_val("done_held", {30'd0, done1, done0}, exp_one);
               check_val("target_held", jump_target, exp_t);
            end
            if (w) req1 = 1'b0; else req0 = 1'b0;
         end
         step;
         check_idle("release");
         pend[w] = 1'b0;
         $display("txn: req%0d served target=%h early=%0d hold=%0d", w, exp_t, early, hold);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_idle(tag);
      check_val({tag, "_target"}, jump_target, 32'd0);
      check_val({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
   endtask

   // Reset asynchronously after 'cycles' edges of a tie (1 = CALC, 2 = DONE).
   task automatic reset_mid(input int cycles);
      pc0 = 32'h0000_3003; offset0 = 32'h0000_0010;
      pc1 = 32'h0000_4000; offset1 = 32'h0000_0001;
      req0 = 1'b1; req1 = 1'b1;
      repeat (cycles) step;
      #1 rst_n = 1'b0;
      #1 check_reset_state("async_reset");
      req0 = 1'b0; req1 = 1'b0;
      last_win = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      $display("txn: reset after %0d cycles of a tie", cycles);
      serve(2'b11, 1'b0, 0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      pc0 = '0; offset0 = '0; pc1 = '0; offset1 = '0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Tie from reset, twice: requester 0 is first each time.
      pc0 = 32'h0000_0200; offset0 = 32'h0000_0020;
      pc1 = 32'h0000_0300; offset1 = 32'h0000_0030;
      serve(2'b11, 1'b0, 1, 1'b0);
      serve(2'b11, 1'b0, 0, 1'b0);

      pc0 = 32'h0000_1000; offset0 = 32'h0000_0040;
      serve(2'b01, 1'b0, 0, 1'b0);
      pc1 = 32'hFFFF_FFFC; offset1 = 32'h0000_0008;
      serve(2'b10, 1'b0, 1, 1'b0);
      pc1 = 32'h0000_0100; offset1 = 32'hFFFF_FFF0;
      serve(2'b10, 1'b0, 0, 1'b0);
      pc0 = 32'h0000_2000; offset0 = 32'h0000_0006;
      serve(2'b01, 1'b0, 2, 1'b0);
      pc0 = 32'h0000_5000; offset0 = 32'h0000_0100;
      serve(2'b01, 1'b1, 0, 1'b1);

      reset_mid(1);
      reset_mid(2);

      for (int n = 0; n < 40; n++) begin
         bit [1:0] mask;
         mask    = 2'($urandom_range(1, 3));
         pc0     = $urandom; offset0 = $urandom;
         pc1     = $urandom; offset1 = $urandom;
         serve(mask, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Mutual exclusion and done-implies-grant on every falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (grant0 && grant1) begin
            miscompares++;
            $display("FAIL both_grants: got grant0=%0b grant1=%0b expected one-hot", grant0, grant1);
         end
         if ((done0 && !grant0) || (done1 && !grant1)) begin
            miscompares++;
            $display("FAIL done_without_grant: got done=%0b%0b grant=%0b%0b", done1, done0, grant1, grant0);
         end
      end
   end

endmodule

// File: doc/jump_target_arbiter.md
# jump_target_arbiter

Sequencer that shares one 32-bit jump-target adder (PC + offset) between two requesters in the multicycle CPU: requester 0 is the branch path, requester 1 is the jump/PC-update path. It arbitrates round-robin and captures the winner's operands. It computes the target over a fixed two-cycle sequence, then holds the registered result and a per-requester done flag until that requester releases its request (four-phase handshake).

## Interface
- word_size, 32, width of PC, offset and target
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  request from branch path; held high until done0 seen
- pc0  in  word_size  branch PC operand
- offset0  in  word_size  branch offset operand (two's complement)
- req1  in  1  request from jump path
- pc1  in  word_size  jump PC operand
- offset1  in  word_size  jump offset operand
- grant0  out  1  requester 0 owns the adder (GRANT..DONE)
- grant1  out  1  requester 1 owns the adder
- done0  out  1  target valid for requester 0
- done1  out  1  target valid for requester 1
- jump_target  out  word_size  registered sum, valid while doneN high
- misaligned  out  1  jump_target[1:0] != 0, valid with doneN
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE: if any req high at clock edge, pick the winner, latch pcN/offsetN into operand registers, set grantN, go CALC. Otherwise stay.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester that did not win last wins.
  - last_winner resets to 1, so requester 0 wins the first tie.
  - last_winner updates when entering CALC.
- CALC: jump_target <= op_pc + op_off, modulo 2^word_size; carry discarded, no overflow flag. misaligned registered from the sum's low bits. Assert doneN for the granted requester, go DONE.
- DONE: hold jump_target, misaligned, grantN, doneN. When the granted reqN is sampled low, clear grantN and doneN and go IDLE.
- Operands are sampled once, at the IDLE->CALC edge. Later changes on pcN/offsetN have no effect.
- Granted req dropping during CALC: computation completes, doneN is high for exactly one cycle (DONE sees req low), then IDLE.
- Losing requester keeps req high. It is served after the next IDLE edge. No request is lost.
- jump_target keeps its last value in IDLE; it is qualified only by doneN.
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE, last_winner = 1.
  - grant0, grant1, done0, done1, busy, misaligned = 0.
  - jump_target = 0.
  - Any in-flight computation is dropped.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Edge E0: req sampled in IDLE; grantN and busy rise.
- Edge E0+1: jump_target, misaligned and doneN valid.
- Latency from request sampled to target valid: 2 cycles.
- Release: reqN low sampled at edge Ek; doneN, grantN and busy fall after Ek.
- A new grant is possible at Ek+1 at the earliest.
- Minimum back-to-back throughput: one result per 3 cycles.
- grant0 and grant1 are never high together. doneN implies grantN.

## Structure
- Shared package jump_pkg:
  - word_size default.
  - State encoding constants: S_IDLE=0, S_CALC=1, S_DONE=2.
  - Requester index constants: REQ_BRANCH=0, REQ_JUMP=1.
- Sub-module target_adder (word_size-parameterised combinational sum: target = pc + offset) instanced once in the CALC datapath.
- The arbiter, FSM and output registers live in the top module.

## Test plan
- Single request: req0=1, pc0=0x0000_1000, offset0=0x0000_0040 -> grant0 after 1 edge; done0, jump_target=0x0000_1040 and misaligned=0 after 2 edges. Drop req0 -> IDLE next edge.
- Wrap and negative offset:
  - pc1=0xFFFF_FFFC, offset1=0x0000_0008 -> jump_target=0x0000_0004.
  - pc1=0x0000_0100, offset1=0xFFFF_FFF0 -> jump_target=0x0000_00F0.
- Tie and fairness: req0 and req1 high together from reset, held until done -> requester 0 served first, then requester 1. Repeat the tie -> requester 0 again, since last winner was 1. Never both grants high.
- Misalignment: pc0=0x0000_2000, offset0=0x0000_0006 -> jump_target=0x0000_2006, misaligned=1 together with done0.
- Early release and operand change: change pc0 after grant, drop req0 during CALC -> result uses the original operands, done0 high exactly one cycle.
- Reset mid-operation: assert rst_n=0 in CALC and in DONE -> all outputs 0 immediately (asynchronously). After release, a tie is granted to requester 0.
